// File: rtl/acionador_bomba.sv
// Pump driver for the irrigation controller: runs the pump for a commanded number of
// milliseconds, honours the low-tank and manual-stop interlocks, then enforces a rest period.
module acionador_bomba #(
  parameter int CICLOS_POR_MS = 50000,
  parameter int TEMPO_MAX_MS  = 30000,
  parameter int PAUSA_MS      = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd_tempo_bomba_ms,
  input  logic        cmd_valido,
  output logic        cmd_pronto,
  input  logic        alerta_nivel_baixo,
  input  logic        parar,
  output logic        bomba_on,
  output logic [15:0] tempo_restante_ms,
  output logic        ciclo_concluido,
  output logic        ciclo_abortado,
  output logic [1:0]  estado
);

  localparam int PRE_W = (CICLOS_POR_MS > 1) ? $clog2(CICLOS_POR_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CICLOS_POR_MS - 1);
  localparam logic [15:0] TEMPO_MAX = (TEMPO_MAX_MS > 65535) ? 16'hFFFF : 16'(TEMPO_MAX_MS);
  localparam logic [15:0] PAUSA_INI = (PAUSA_MS > 65535) ? 16'hFFFF : 16'(PAUSA_MS);

  typedef enum logic [1:0] {
    OCIOSO    = 2'b00,
    IRRIGANDO = 2'b01,
    PAUSA     = 2'b10
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [PRE_W-1:0] prescaler_q, prescaler_d;
  logic [15:0]      tempo_q, tempo_d;
  logic [15:0]      pausa_q, pausa_d;
  logic             bomba_q, bomba_d;
  logic             concluido_q, concluido_d;
  logic             abortado_q, abortado_d;
  logic             pronto_q, pronto_d;

  logic             wrap;
  logic             interlock;
  logic             aceito;
  logic [15:0]      tempo_carga;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q    <= OCIOSO;
      prescaler_q <= '0;
      tempo_q     <= '0;
      pausa_q     <= '0;
      bomba_q     <= 1'b0;
      concluido_q <= 1'b0;
      abortado_q  <= 1'b0;
      pronto_q    <= 1'b1;
    end else begin
      estado_q    <= estado_d;
      prescaler_q <= prescaler_d;
      tempo_q     <= tempo_d;
      pausa_q     <= pausa_d;
      bomba_q     <= bomba_d;
      concluido_q <= concluido_d;
      abortado_q  <= abortado_d;
      pronto_q    <= pronto_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    prescaler_d = prescaler_q;
    tempo_d     = tempo_q;
    pausa_d     = pausa_q;
    bomba_d     = bomba_q;
    concluido_d = 1'b0;
    abortado_d  = 1'b0;

    wrap        = (prescaler_q == PRE_MAX);
    interlock   = alerta_nivel_baixo | parar;
    aceito      = cmd_valido & pronto_q;
    tempo_carga = (cmd_tempo_bomba_ms > TEMPO_MAX) ? TEMPO_MAX : cmd_tempo_bomba_ms;

    case (estado_q)
      OCIOSO: begin
        bomba_d     = 1'b0;
        tempo_d     = '0;
        prescaler_d = '0;
        // A zero-length request is silently dropped; an interlocked one is reported.
        if (aceito && (cmd_tempo_bomba_ms != 16'd0)) begin
          if (interlock) begin
            abortado_d = 1'b1;
          end else begin
            tempo_d  = tempo_carga;
            bomba_d  = 1'b1;
            estado_d = IRRIGANDO;
          end
        end
      end

      IRRIGANDO: begin
        // The interlock is checked first so an abort beats the last-millisecond completion.
        if (interlock) begin
          bomba_d     = 1'b0;
          tempo_d     = '0;
          prescaler_d = '0;
          pausa_d     = PAUSA_INI;
          abortado_d  = 1'b1;
          estado_d    = PAUSA;
        end else if (wrap) begin
          prescaler_d = '0;
          if (tempo_q <= 16'd1) begin
            bomba_d     = 1'b0;
            tempo_d     = '0;
            pausa_d     = PAUSA_INI;
            concluido_d = 1'b1;
            estado_d    = PAUSA;
          end else begin
            tempo_d = tempo_q - 16'd1;
          end
        end else begin
          prescaler_d = prescaler_q + PRE_W'(1);
        end
      end

      PAUSA: begin
        bomba_d = 1'b0;
        tempo_d = '0;
        if (pausa_q == 16'd0) begin
          prescaler_d = '0;
          estado_d    = OCIOSO;
        end else if (wrap) begin
          prescaler_d = '0;
          if (pausa_q == 16'd1) begin
            pausa_d  = '0;
            estado_d = OCIOSO;
          end else begin
            pausa_d = pausa_q - 16'd1;
          end
        end else begin
          prescaler_d = prescaler_q + PRE_W'(1);
        end
      end

      default: begin
        estado_d    = OCIOSO;
        bomba_d     = 1'b0;
        tempo_d     = '0;
        pausa_d     = '0;
        prescaler_d = '0;
      end
    endcase

    pronto_d = (estado_d == OCIOSO);
  end

  assign cmd_pronto        = pronto_q;
  assign bomba_on          = bomba_q;
  assign tempo_restante_ms = tempo_q;
  assign ciclo_concluido   = concluido_q;
  assign ciclo_abortado    = abortado_q;
  assign estado            = estado_q;

endmodule

// File: tb/tb_acionador_bomba.sv
// Scoreboard bench for acionador_bomba: stimulus queues expected events, a negedge
// monitor turns pump runs, pause runs, loads and pulses into events and compares them.
module tb_acionador_bomba;

  localparam int CPM  = 4;
  localparam int PMS  = 2;
  localparam int TMAX = 10;

  logic        clk;
  logic        rst_n;
  logic [15:0] cmd_tempo_bomba_ms;
  logic        cmd_valido;
  logic        cmd_pronto;
  logic        alerta_nivel_baixo;
  logic        parar;
  logic        bomba_on;
  logic [15:0] tempo_restante_ms;
  logic        ciclo_concluido;
  logic        ciclo_abortado;
  logic [1:0]  estado;

  acionador_bomba #(
    .CICLOS_POR_MS(CPM),
    .TEMPO_MAX_MS (TMAX),
    .PAUSA_MS     (PMS)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cmd_tempo_bomba_ms(cmd_tempo_bomba_ms),
    .cmd_valido        (cmd_valido),
    .cmd_pronto        (cmd_pronto),
    .alerta_nivel_baixo(alerta_nivel_baixo),
    .parar             (parar),
    .bomba_on          (bomba_on),
    .tempo_restante_ms (tempo_restante_ms),
    .ciclo_concluido   (ciclo_concluido),
    .ciclo_abortado    (ciclo_abortado),
    .estado            (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {EV_LOAD, EV_BOMBA, EV_CONC, EV_ABORT, EV_PAUSA} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       value;
  } ev_t;

  ev_t  exp_q[$];
  int   n_checks;
  int   n_errors;
  bit   mon_en;
  int   mon_bomba_len;
  int   mon_pausa_len;
  logic [1:0] mon_prev_estado;

  task automatic expectEvent(input ev_kind_t k, input int v);
    ev_t e;
    e.kind  = k;
    e.value = v;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic reportEvent(input ev_kind_t k, input int v);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("[TB] FAIL event: got %s=%0d, expected no event", k.name(), v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.value != v) begin
        n_errors++;
        $display("[TB] FAIL event: got %s=%0d, expected %s=%0d", k.name(), v, e.kind.name(), e.value);
      end
    end
  endtask

  // Monitor: event order within one sample is LOAD, BOMBA, CONC, ABORT, PAUSA.
  initial begin
    mon_bomba_len   = 0;
    mon_pausa_len   = 0;
    mon_prev_estado = 2'b00;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (estado === 2'b01 && mon_prev_estado !== 2'b01)
          reportEvent(EV_LOAD, int'(tempo_restante_ms));
        if (bomba_on === 1'b1) begin
          mon_bomba_len++;
        end else if (mon_bomba_len > 0) begin
          reportEvent(EV_BOMBA, mon_bomba_len);
          mon_bomba_len = 0;
        end
        if (ciclo_concluido === 1'b1) reportEvent(EV_CONC, 0);
        if (ciclo_abortado === 1'b1)  reportEvent(EV_ABORT, 0);
        if (estado === 2'b10) begin
          mon_pausa_len++;
        end else if (mon_pausa_len > 0) begin
          reportEvent(EV_PAUSA, mon_pausa_len);
          mon_pausa_len = 0;
        end
        mon_prev_estado = estado;
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] tempo);
    int n = 0;
    while (cmd_pronto !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("ready_before_cmd", {31'd0, cmd_pronto}, 32'd1);
    cmd_tempo_bomba_ms = tempo;
    cmd_valido         = 1'b1;
    @(posedge clk);
    #1;
    cmd_valido = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (!(cmd_pronto === 1'b1 && estado === 2'b00) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("idle_reached", {31'd0, (cmd_pronto === 1'b1 && estado === 2'b00)}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks           = 0;
    n_errors           = 0;
    mon_en             = 1'b0;
    rst_n              = 1'b0;
    cmd_tempo_bomba_ms = '0;
    cmd_valido         = 1'b0;
    alerta_nivel_baixo = 1'b0;
    parar              = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    checkOutput("rst_estado", {30'd0, estado}, 32'd0);
    checkOutput("rst_bomba", {31'd0, bomba_on}, 32'd0);
    checkOutput("rst_tempo", {16'd0, tempo_restante_ms}, 32'd0);
    checkOutput("rst_concluido", {31'd0, ciclo_concluido}, 32'd0);
    checkOutput("rst_abortado", {31'd0, ciclo_abortado}, 32'd0);
    checkOutput("rst_pronto", {31'd0, cmd_pronto}, 32'd1);
    rst_n = 1'b1;

    $display("[TB] normal 3 ms cycle");
    expectEvent(EV_LOAD, 3);
    expectEvent(EV_BOMBA, 12);
    expectEvent(EV_CONC, 0);
    expectEvent(EV_PAUSA, 8);
    applyStimulus(16'd3);
    checkOutput("t1_bomba_on", {31'd0, bomba_on}, 32'd1);
    checkOutput("t1_estado", {30'd0, estado}, 32'd1);
    checkOutput("t1_pronto_low", {31'd0, cmd_pronto}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t1_tempo_dec", {16'd0, tempo_restante_ms}, 32'd2);
    waitIdle(100);
    checkOutput("t1_pronto_after", {31'd0, cmd_pronto}, 32'd1);

    $display("[TB] saturated 25 ms request");
    expectEvent(EV_LOAD, 10);
    expectEvent(EV_BOMBA, 40);
    expectEvent(EV_CONC, 0);
    expectEvent(EV_PAUSA, 8);
    applyStimulus(16'd25);
    waitIdle(200);

    $display("[TB] low tank abort during irrigation");
    expectEvent(EV_LOAD, 5);
    expectEvent(EV_BOMBA, 7);
    expectEvent(EV_ABORT, 0);
    expectEvent(EV_PAUSA, 8);
    applyStimulus(16'd5);
    repeat (6) @(posedge clk);
    #1;
    alerta_nivel_baixo = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t3_bomba_off", {31'd0, bomba_on}, 32'd0);
    checkOutput("t3_tempo_zero", {16'd0, tempo_restante_ms}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    alerta_nivel_baixo = 1'b0;
    waitIdle(100);

    $display("[TB] rejected and zero-length commands");
    alerta_nivel_baixo = 1'b1;
    expectEvent(EV_ABORT, 0);
    applyStimulus(16'd4);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t4_estado", {30'd0, estado}, 32'd0);
    checkOutput("t4_bomba", {31'd0, bomba_on}, 32'd0);
    checkOutput("t4_pronto", {31'd0, cmd_pronto}, 32'd1);
    alerta_nivel_baixo = 1'b0;
    applyStimulus(16'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t4_zero_estado", {30'd0, estado}, 32'd0);
    checkOutput("t4_zero_pronto", {31'd0, cmd_pronto}, 32'd1);

    $display("[TB] stop on final wrap, second command ignored");
    expectEvent(EV_LOAD, 2);
    expectEvent(EV_BOMBA, 8);
    expectEvent(EV_ABORT, 0);
    expectEvent(EV_PAUSA, 8);
    applyStimulus(16'd2);
    repeat (2) @(posedge clk);
    #1;
    cmd_tempo_bomba_ms = 16'd3;
    cmd_valido         = 1'b1;
    @(posedge clk);
    #1;
    cmd_valido = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    parar = 1'b1;
    @(posedge clk);
    #1;
    parar = 1'b0;
    waitIdle(100);

    $display("[TB] reset during irrigation");
    expectEvent(EV_LOAD, 3);
    expectEvent(EV_BOMBA, 5);
    applyStimulus(16'd3);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t6_bomba", {31'd0, bomba_on}, 32'd0);
    checkOutput("t6_estado", {30'd0, estado}, 32'd0);
    checkOutput("t6_tempo", {16'd0, tempo_restante_ms}, 32'd0);
    checkOutput("t6_concluido", {31'd0, ciclo_concluido}, 32'd0);
    checkOutput("t6_abortado", {31'd0, ciclo_abortado}, 32'd0);
    checkOutput("t6_pronto", {31'd0, cmd_pronto}, 32'd1);
    rst_n = 1'b1;
    expectEvent(EV_LOAD, 1);
    expectEvent(EV_BOMBA, 4);
    expectEvent(EV_CONC, 0);
    expectEvent(EV_PAUSA, 8);
    applyStimulus(16'd1);
    waitIdle(100);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("events_pending", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/acionador_bomba.md
ACIONADOR_BOMBA -- requirements
Module: acionador_bomba

Interface
REQ-001 SHALL have parameter CICLOS_POR_MS, default 50000, clk cycles per millisecond (50 MHz).
REQ-002 SHALL have parameter TEMPO_MAX_MS, default 30000, saturation ceiling for a commanded pump time.
REQ-003 SHALL have parameter PAUSA_MS, default 1000, mandatory pump-off rest after every irrigation cycle.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port cmd_tempo_bomba_ms  input  16  requested pump-on time in ms, from the irrigation decision block.
REQ-007 SHALL have port cmd_valido  input  1  request qualifier; command taken when cmd_valido and cmd_pronto are both high on a clock edge.
REQ-008 SHALL have port cmd_pronto  output  1  high only in state OCIOSO.
REQ-009 SHALL have port alerta_nivel_baixo  input  1  low-tank safety interlock.
REQ-010 SHALL have port parar  input  1  manual stop.
REQ-011 SHALL have port bomba_on  output  1  registered pump drive.
REQ-012 SHALL have port tempo_restante_ms  output  16  ms remaining in current irrigation; 0 outside IRRIGANDO.
REQ-013 SHALL have port ciclo_concluido  output  1  one-cycle pulse on normal completion.
REQ-014 SHALL have port ciclo_abortado  output  1  one-cycle pulse on abort or rejected command.
REQ-015 SHALL have port estado  output  2  OCIOSO=00, IRRIGANDO=01, PAUSA=10; 11 unused.

Function
REQ-016 SHALL implement a three-state FSM OCIOSO, IRRIGANDO, PAUSA; all outputs registered.
REQ-017 OCIOSO, accepted command, tempo=0: SHALL discard it, no pulse, stay OCIOSO.
REQ-018 OCIOSO, accepted command, alerta_nivel_baixo or parar high: SHALL reject, pulse ciclo_abortado next cycle, stay OCIOSO, bomba_on stays 0.
REQ-019 OCIOSO, accepted command, tempo>0, no alerta/parar: SHALL load tempo_restante_ms = min(tempo, TEMPO_MAX_MS), clear prescaler, enter IRRIGANDO; bomba_on=1 from the next cycle.
REQ-020 IRRIGANDO: prescaler SHALL count 0..CICLOS_POR_MS-1 and wrap; at wrap tempo_restante_ms decrements by 1.
REQ-021 bomba_on SHALL be high for exactly N*CICLOS_POR_MS cycles for a loaded value N with no abort.
REQ-022 Wrap with tempo_restante_ms=1: SHALL set bomba_on=0, tempo_restante_ms=0, pulse ciclo_concluido, enter PAUSA, same edge.
REQ-023 IRRIGANDO, alerta_nivel_baixo or parar sampled high: SHALL drive bomba_on=0 on the next edge, zero tempo_restante_ms, pulse ciclo_abortado, enter PAUSA.
REQ-024 Abort and final-ms wrap on the same edge: abort SHALL win (ciclo_abortado only, never both pulses).
REQ-025 cmd_valido while not in OCIOSO SHALL be ignored, not queued.
REQ-026 PAUSA: bomba_on=0; SHALL count PAUSA_MS ms via the same prescaler, then return to OCIOSO; PAUSA_MS=0 gives exactly one cycle in PAUSA.
REQ-027 alerta_nivel_baixo/parar in PAUSA SHALL not extend or shorten the pause.
REQ-028 Prescaler width SHALL be clog2(CICLOS_POR_MS); ms counters 16 bits, no wrap below 0.

Reset
REQ-029 rst_n low at a clock edge SHALL force estado=OCIOSO, bomba_on=0, tempo_restante_ms=0, prescaler=0, ciclo_concluido=0, ciclo_abortado=0, cmd_pronto=1 on that edge, including mid-IRRIGANDO (no pulse emitted, no PAUSA entered).
REQ-030 First command SHALL be accepted on the first edge with rst_n high.

Verification (bench with CICLOS_POR_MS=4, PAUSA_MS=2, TEMPO_MAX_MS=10)
REQ-031 cmd 3 ms, clean inputs -> bomba_on high exactly 12 cycles starting cycle after accept, ciclo_concluido one pulse, 8 cycles PAUSA, then cmd_pronto=1.
REQ-032 cmd 25 ms -> tempo_restante_ms loads 10, bomba_on high 40 cycles.
REQ-033 cmd 5 ms, alerta_nivel_baixo raised at cycle 7 of IRRIGANDO -> bomba_on 0 next edge, ciclo_abortado one pulse, no ciclo_concluido, PAUSA 8 cycles.
REQ-034 cmd 4 ms with alerta_nivel_baixo already high -> ciclo_abortado pulse, bomba_on never 1, estado stays 00; cmd 0 ms -> no pulse, no state change.
REQ-035 parar asserted on the exact edge of the final-ms wrap -> ciclo_abortado only; second cmd_valido during IRRIGANDO ignored.
REQ-036 rst_n low mid-IRRIGANDO -> next edge bomba_on=0, estado=00, no pulses; new 1 ms cmd after release gives 4 cycles of bomba_on.
